// File: rtl/ripple_mon_pkg.sv
// Shared types and default sizing for the ripple count monitor.
package ripple_mon_pkg;

  localparam int unsigned DefN            = 4;
  localparam int unsigned DefStableCycles = 2;
  localparam int unsigned DefWrapW        = 8;

  typedef enum logic {
    StAcq,
    StRun
  } state_e;

endpackage

// File: rtl/ripple_sync_stage.sv
// Two-flop synchronizer for an asynchronous ripple count, followed by a stability filter that
// pulses accept once the synchronized value has held for STABLE_CYCLES consecutive samples.
module ripple_sync_stage #(
  parameter int unsigned N             = ripple_mon_pkg::DefN,
  parameter int unsigned STABLE_CYCLES = ripple_mon_pkg::DefStableCycles
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] cnt_in,
  output logic         accept,
  output logic [N-1:0] value
);

  localparam logic [3:0] Target = 4'(STABLE_CYCLES);

  logic [N-1:0] sync1_q, sync2_q, last_q;
  logic [1:0]   fill_q;
  logic [3:0]   run_q, run_d;
  logic         same;

  // run_q == 0 means no sample has been taken yet since reset
  assign same  = (sync2_q == last_q) && (run_q != 4'd0);
  assign value = sync2_q;

  always_comb begin
    run_d  = run_q;
    accept = 1'b0;
    // fill_q masks the reset-zero contents of the synchronizer until real data arrives
    if (fill_q[1]) begin
      if (!same) begin
        run_d = 4'd1;
      end else if (run_q != Target) begin
        run_d = run_q + 4'd1;
      end
      // Fire only on reaching the target, never while parked there on an unchanged value
      accept = (run_d == Target) && !(same && (run_q == Target));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      fill_q  <= '0;
      run_q   <= '0;
    end else begin
      sync1_q <= cnt_in;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1]) begin
        last_q <= sync2_q;
      end
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// Tracks a ripple down-counter, reporting 0 -> max wraps through a valid/ready event.
// Skip detection is built only when RIPPLE_MON_SKIP_DETECT_EN is defined.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int unsigned N             = DefN,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned WRAP_W        = DefWrapW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      cnt_in,
  output logic [N-1:0]      count_q,
  output logic              count_valid,
  output logic              wrap_valid,
  input  logic              wrap_ready,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              wrap_ovf,
  output logic              skip_err
);

  state_e            state_q, state_d;
  logic [N-1:0]      count_d, acc_value, prev_dec;
  logic              accept, wrap;
  logic              wrap_valid_q, wrap_valid_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_ovf_q, wrap_ovf_d;
`ifdef RIPPLE_MON_SKIP_DETECT_EN
  logic              skip_q, skip_d;
`endif

  ripple_sync_stage #(
    .N            (N),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_in(cnt_in),
    .accept(accept),
    .value (acc_value)
  );

  assign prev_dec = count_q - N'(1);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wrap         = 1'b0;
    wrap_valid_d = wrap_valid_q && !wrap_ready;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_ovf_d   = wrap_ovf_q;
`ifdef RIPPLE_MON_SKIP_DETECT_EN
    skip_d       = skip_q;
`endif
    if (accept) begin
      unique case (state_q)
        StAcq: begin
          count_d = acc_value;
          state_d = StRun;
        end
        StRun: begin
          if (acc_value != count_q) begin
            count_d = acc_value;
            if (acc_value == prev_dec) begin
              wrap = (count_q == '0);
            end else begin
`ifdef RIPPLE_MON_SKIP_DETECT_EN
              skip_d = 1'b1;
`endif
            end
          end
        end
        default: state_d = StAcq;
      endcase
    end
    // A new wrap on the consuming edge keeps the event pending rather than overflowing
    if (wrap) begin
      wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
      wrap_valid_d = 1'b1;
      if (wrap_valid_q && !wrap_ready) begin
        wrap_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAcq;
      count_q      <= '0;
      wrap_valid_q <= 1'b0;
      wrap_cnt_q   <= '0;
      wrap_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wrap_valid_q <= wrap_valid_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_ovf_q   <= wrap_ovf_d;
    end
  end

`ifdef RIPPLE_MON_SKIP_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
  assign skip_err = skip_q;
`else
  assign skip_err = 1'b0;
`endif

  assign count_valid = (state_q == StRun);
  assign wrap_valid  = wrap_valid_q;
  assign wrap_cnt    = wrap_cnt_q;
  assign wrap_ovf    = wrap_ovf_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Scoreboard bench for ripple_count_monitor: stimulus pushes expected acceptance records,
// a negedge monitor pops and compares whenever the accepted count changes.
module tb_ripple_count_monitor;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int W    = 8;
  localparam int MaxV = (1 << N) - 1;
`ifdef RIPPLE_MON_SKIP_DETECT_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] cnt_in;
  logic [N-1:0] count_q;
  logic         count_valid, wrap_valid, wrap_ready, wrap_ovf, skip_err;
  logic [W-1:0] wrap_cnt;

  always #5 clk = ~clk;

  ripple_count_monitor #(
    .N            (N),
    .STABLE_CYCLES(S),
    .WRAP_W       (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_in     (cnt_in),
    .count_q    (count_q),
    .count_valid(count_valid),
    .wrap_valid (wrap_valid),
    .wrap_ready (wrap_ready),
    .wrap_cnt   (wrap_cnt),
    .wrap_ovf   (wrap_ovf),
    .skip_err   (skip_err)
  );

  typedef struct {
    int cq;
    int wc;
    bit ovf;
    bit skip;
    bit wv;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   wv_cycles = 0;

  // Reference model state, in terms of accepted counts and pending events
  int m_prev;
  int m_wc;
  bit m_ovf, m_skip, m_pend;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a change in the accepted count (or first validity) is one DUT output event
  bit pcv = 1'b0;
  int pcq = 0;
  always @(negedge clk) begin
    if (wrap_valid) wv_cycles++;
    if (!rst_n) begin
      pcv = 1'b0;
      pcq = 0;
    end else begin
      if (count_valid && (!pcv || int'(count_q) != pcq)) begin
        if (q.size() == 0) begin
          chk("unexpected count update", int'(count_q), pcq);
        end else begin
          rec_t e;
          e = q.pop_front();
          chk("sb count_q", int'(count_q), e.cq);
          chk("sb wrap_cnt", int'(wrap_cnt), e.wc);
          chk("sb wrap_ovf", int'(wrap_ovf), int'(e.ovf));
          chk("sb skip_err", int'(skip_err), int'(e.skip));
          chk("sb wrap_valid", int'(wrap_valid), int'(e.wv));
        end
      end
      pcv = count_valid;
      pcq = int'(count_q);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold v for `hold` clocks with wrap_ready=r, predicting the acceptance outcome
  task automatic seg(input int v, input bit r, input int hold);
    bit wrap, dec;
    cnt_in     = N'(v);
    wrap_ready = r;
    if (r) m_pend = 1'b0;
    if (v != m_prev) begin
      dec  = (v == (m_prev + MaxV) % (MaxV + 1));
      wrap = (m_prev == 0) && (v == MaxV);
      if (wrap) begin
        if (m_pend && !r) m_ovf = 1'b1;
        m_wc   = (m_wc + 1) % (1 << W);
        m_pend = 1'b1;
      end
      if (!dec && SkipEn) m_skip = 1'b1;
      q.push_back('{v, m_wc, m_ovf, m_skip, m_pend});
      if (r) m_pend = 1'b0;
      m_prev = v;
    end
    tick(hold);
  endtask

  // Reset with v on the input; first acceptance must land exactly 2+S clocks after release
  task automatic do_reset(input int v);
    chk("queue drained before reset", q.size(), 0);
    q.delete();
    rst_n      = 1'b0;
    cnt_in     = N'(v);
    wrap_ready = 1'b1;
    tick(3);
    chk("rst count_q", int'(count_q), 0);
    chk("rst count_valid", int'(count_valid), 0);
    chk("rst wrap_valid", int'(wrap_valid), 0);
    chk("rst wrap_cnt", int'(wrap_cnt), 0);
    chk("rst wrap_ovf", int'(wrap_ovf), 0);
    chk("rst skip_err", int'(skip_err), 0);
    m_prev = v;
    m_wc   = 0;
    m_ovf  = 1'b0;
    m_skip = 1'b0;
    m_pend = 1'b0;
    q.push_back('{v, 0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    tick(S + 1);
    chk("latency count_valid early", int'(count_valid), 0);
    tick(1);
    chk("latency count_valid", int'(count_valid), 1);
    chk("latency count_q", int'(count_q), v);
    tick(2);
  endtask

  initial begin
    int v;
    rst_n      = 1'b0;
    cnt_in     = '0;
    wrap_ready = 1'b0;
    tick(2);

    do_reset(5);
    chk("hold5 wrap_valid", int'(wrap_valid), 0);
    chk("hold5 skip_err", int'(skip_err), 0);

    // Single wrap consumed immediately
    do_reset(1);
    seg(0, 1'b1, 6);
    wv_cycles = 0;
    seg(MaxV, 1'b1, 6);
    chk("wrap pulse cycles", wv_cycles, 1);
    chk("wrap1 wrap_cnt", int'(wrap_cnt), 1);
    chk("wrap1 wrap_ovf", int'(wrap_ovf), 0);

    // Two unconsumed wraps overflow
    do_reset(1);
    seg(0, 1'b0, 6);
    seg(MaxV, 1'b0, 6);
    seg(0, 1'b0, 6);
    seg(MaxV, 1'b0, 6);
    chk("ovf wrap_valid", int'(wrap_valid), 1);
    chk("ovf wrap_cnt", int'(wrap_cnt), 2);
    chk("ovf wrap_ovf", int'(wrap_ovf), 1);
    seg(MaxV, 1'b1, 6);
    chk("ovf consumed wrap_valid", int'(wrap_valid), 0);
    chk("ovf sticky wrap_ovf", int'(wrap_ovf), 1);

    // One-clock glitch must be filtered out
    seg(7, 1'b1, 8);
    cnt_in = N'(3);
    tick(1);
    cnt_in = N'(7);
    tick(8);
    chk("glitch count_q", int'(count_q), 7);
    chk("glitch wrap_valid", int'(wrap_valid), 0);
    chk("glitch skip_err", int'(skip_err), int'(m_skip));
    chk("glitch wrap_cnt", int'(wrap_cnt), m_wc);

    // Jump 9 -> 4
    do_reset(9);
    seg(4, 1'b1, 6);
    chk("jump count_q", int'(count_q), 4);
    chk("jump skip_err", int'(skip_err), int'(SkipEn));

    // Reset while a wrap is pending discards it
    do_reset(1);
    seg(0, 1'b0, 6);
    seg(MaxV, 1'b0, 6);
    chk("pre-reset wrap_valid", int'(wrap_valid), 1);
    do_reset(MaxV);
    chk("post-reset wrap_valid", int'(wrap_valid), 0);
    chk("post-reset wrap_cnt", int'(wrap_cnt), 0);

    // Randomized walk, biased toward decrements so wraps occur often
    do_reset($urandom_range(MaxV, 0));
    for (int i = 0; i < 90; i++) begin
      int mode;
      mode = $urandom_range(9, 0);
      if (mode < 7)       v = (m_prev + MaxV) % (MaxV + 1);
      else if (mode == 7) v = m_prev;
      else                v = $urandom_range(MaxV, 0);
      seg(v, 1'($urandom_range(1, 0)), $urandom_range(9, 6));
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
    chk("final queue drained", q.size(), 0);
    chk("final count_q", int'(count_q), m_prev);
    chk("final wrap_cnt", int'(wrap_cnt), m_wc);
    chk("final wrap_ovf", int'(wrap_ovf), int'(m_ovf));
    chk("final skip_err", int'(skip_err), int'(m_skip));
    chk("final wrap_valid", int'(wrap_valid), int'(m_pend));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors + 1);
    $fatal(1);
  end

endmodule
